// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB completer with a DEPTH x DATA_W register file and programmable wait states
module apb_slave_regfile #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              PCLK,
  input  logic              PRESET_n,
  input  logic              PSEL_i,
  input  logic              PENABLE_i,
  input  logic              PWRITE_i,
  input  logic [ADDR_W-1:0] PADDR_i,
  input  logic [DATA_W-1:0] PWDATA_i,
  output logic              PREADY_o,
  output logic [DATA_W-1:0] PRDATA_o,
  output logic              PSLVERR_o
);

  localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U  = 32'(DEPTH);
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx_q, idx_n;
  logic              write_q, write_n;
  logic              err_q, err_n;
  logic [3:0]        cnt, cnt_n;
  logic              pready_n;
  logic              pslverr_n;
  logic [DATA_W-1:0] prdata_n;
  logic              mem_we;
  logic              setup_err;
  logic [IDX_W-1:0]  setup_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  // Full-width compare so aliased high addresses never reach the array
  assign setup_err = (32'(PADDR_i) >= DEPTH_U);
  assign setup_idx = PADDR_i[IDX_W-1:0];

  always_comb begin
    state_n   = state;
    idx_n     = idx_q;
    write_n   = write_q;
    err_n     = err_q;
    cnt_n     = cnt;
    pready_n  = 1'b0;
    pslverr_n = 1'b0;
    prdata_n  = '0;
    mem_we    = 1'b0;
    case (state)
      S_IDLE: begin
        if (PSEL_i && !PENABLE_i) begin
          idx_n   = setup_idx;
          write_n = PWRITE_i;
          err_n   = setup_err;
          if (WAIT_CYCLES == 0) begin
            pready_n  = 1'b1;
            pslverr_n = setup_err;
            if (!PWRITE_i && !setup_err) begin
              prdata_n = mem[setup_idx];
            end
            state_n = S_ACCESS;
          end else begin
            cnt_n   = CNT_INIT;
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!PSEL_i) begin
          state_n = S_IDLE;
        end else if (PENABLE_i) begin
          if (cnt == 4'd0) begin
            pready_n  = 1'b1;
            pslverr_n = err_q;
            if (!write_q && !err_q) begin
              prdata_n = mem[idx_q];
            end
            state_n = S_ACCESS;
          end else begin
            cnt_n = cnt - 4'd1;
          end
        end
      end
      S_ACCESS: begin
        // Completion edge: the write commits before any following setup edge
        mem_we  = write_q && !err_q;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET_n) begin
      state     <= S_IDLE;
      idx_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt       <= 4'd0;
      PREADY_o  <= 1'b0;
      PSLVERR_o <= 1'b0;
      PRDATA_o  <= '0;
    end else begin
      state     <= state_n;
      idx_q     <= idx_n;
      write_q   <= write_n;
      err_q     <= err_n;
      cnt       <= cnt_n;
      PREADY_o  <= pready_n;
      PSLVERR_o <= pslverr_n;
      PRDATA_o  <= prdata_n;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[idx_q] <= PWDATA_i;
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - scoreboard bench: two completers, WAIT_CYCLES=2 (d=0) and WAIT_CYCLES=0 (d=1)
module tb_apb_slave_regfile;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         waits;
  } exp_t;

  logic       PCLK = 1'b0;
  logic       PRESET_n;
  logic       psel    [2];
  logic       penable [2];
  logic       pwrite  [2];
  logic [7:0] paddr   [2];
  logic [7:0] pwdata  [2];
  logic       pready  [2];
  logic [7:0] prdata  [2];
  logic       pslverr [2];

  exp_t q0[$];
  exp_t q1[$];
  int   checks   = 0;
  int   failures = 0;
  int   waits [2];

  always #5 PCLK = ~PCLK;

  apb_slave_regfile #(.ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(2)) dut_w2 (
    .PCLK(PCLK), .PRESET_n(PRESET_n),
    .PSEL_i(psel[0]), .PENABLE_i(penable[0]), .PWRITE_i(pwrite[0]),
    .PADDR_i(paddr[0]), .PWDATA_i(pwdata[0]),
    .PREADY_o(pready[0]), .PRDATA_o(prdata[0]), .PSLVERR_o(pslverr[0])
  );

  apb_slave_regfile #(.ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(0)) dut_w0 (
    .PCLK(PCLK), .PRESET_n(PRESET_n),
    .PSEL_i(psel[1]), .PENABLE_i(penable[1]), .PWRITE_i(pwrite[1]),
    .PADDR_i(paddr[1]), .PWDATA_i(pwdata[1]),
    .PREADY_o(pready[1]), .PRDATA_o(prdata[1]), .PSLVERR_o(pslverr[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per completing access cycle
  always @(negedge PCLK) begin
    if (PRESET_n) begin
      for (int d = 0; d < 2; d++) begin
        if (psel[d] && penable[d]) begin
          if (pready[d]) begin
            exp_t e;
            if ((d == 0 ? q0.size() : q1.size()) == 0) begin
              chk($sformatf("unexpected_pready_d%0d", d), 1, 0);
            end else begin
              e = (d == 0) ? q0.pop_front() : q1.pop_front();
              chk($sformatf("prdata_d%0d", d), prdata[d], e.data);
              chk($sformatf("pslverr_d%0d", d), pslverr[d], e.err);
              chk($sformatf("wait_states_d%0d", d), waits[d], e.waits);
            end
            waits[d] = 0;
          end else begin
            waits[d]++;
          end
        end else begin
          chk($sformatf("stray_pready_d%0d", d), pready[d], 0);
          waits[d] = 0;
        end
      end
    end
  end

  task automatic push(input int d, input logic [7:0] data, input logic err);
    exp_t e;
    e.data  = data;
    e.err   = err;
    e.waits = (d == 0) ? 2 : 0;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Called #1 after a posedge; returns #1 after the completion edge so transfers can run back-to-back
  task automatic xfer(input int d, input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                      input logic [7:0] exp_data, input logic exp_err);
    bit done = 0;
    push(d, exp_data, exp_err);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wdata;
    @(posedge PCLK); #1;
    penable[d] = 1'b1;
    paddr[d]   = ~addr;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge PCLK);
      done = pready[d];
      @(posedge PCLK); #1;
    end
    if (!done) chk($sformatf("timeout_d%0d", d), 0, 1);
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  initial begin
    PRESET_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = 8'h05; pwdata[d] = 8'h00;
      waits[d] = 0;
    end
    repeat (2) begin
      @(posedge PCLK); @(negedge PCLK);
      for (int d = 0; d < 2; d++) begin
        chk("reset_pready", pready[d], 0);
        chk("reset_pslverr", pslverr[d], 0);
        chk("reset_prdata", prdata[d], 0);
      end
    end
    @(posedge PCLK); #1;
    PRESET_n = 1'b1;
    psel[0] = 1'b0; psel[1] = 1'b0;
    idle(1);

    xfer(0, 1'b0, 8'h05, 8'h00, 8'h00, 1'b0);
    xfer(0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0);
    xfer(0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);

    xfer(1, 1'b1, 8'h00, 8'h11, 8'h00, 1'b0);
    xfer(1, 1'b1, 8'h3F, 8'h22, 8'h00, 1'b0);
    xfer(1, 1'b0, 8'h00, 8'h00, 8'h11, 1'b0);
    xfer(1, 1'b0, 8'h3F, 8'h00, 8'h22, 1'b0);
    xfer(1, 1'b1, 8'h40, 8'h99, 8'h00, 1'b1);
    xfer(1, 1'b0, 8'h00, 8'h00, 8'h11, 1'b0);

    xfer(0, 1'b1, 8'h40, 8'h77, 8'h00, 1'b1);
    xfer(0, 1'b0, 8'h40, 8'h00, 8'h00, 1'b1);
    xfer(0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    xfer(0, 1'b1, 8'hFF, 8'h66, 8'h00, 1'b1);
    xfer(0, 1'b0, 8'h3F, 8'h00, 8'h00, 1'b0);

    xfer(0, 1'b1, 8'h08, 8'h33, 8'h00, 1'b0);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h08; pwdata[0] = 8'h5A;
    @(posedge PCLK); #1;
    penable[0] = 1'b1;
    @(posedge PCLK); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    idle(2);
    xfer(0, 1'b0, 8'h08, 8'h00, 8'h33, 1'b0);

    xfer(0, 1'b1, 8'h02, 8'h44, 8'h00, 1'b0);
    push(0, 8'h00, 1'b0);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h02; pwdata[0] = 8'hFF;
    @(posedge PCLK); #1;
    penable[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      if (pready[0]) break;
    end
    #1 PRESET_n = 1'b0;
    @(posedge PCLK); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    chk("midreset_pready", pready[0], 0);
    chk("midreset_pslverr", pslverr[0], 0);
    chk("midreset_prdata", prdata[0], 0);
    PRESET_n = 1'b1;
    idle(1);
    xfer(0, 1'b0, 8'h02, 8'h00, 8'h00, 1'b0);
    xfer(1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);

    idle(3);
    chk("queue_empty_d0", q0.size(), 0);
    chk("queue_empty_d1", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
